// File: rtl/freq_gate_ctrl_if.sv
// Control/status bundle for the frequency-counter gate controller.
// The master side (the system or testbench) drives the requests and the
// digit-chain carry. The slave side (freq_gate_ctrl) drives the chain
// controls and the status outputs.
//   run, single, abort : measurement requests (master -> slave)
//   chain_carry        : carry out of the most-significant BCD digit
//   ctr_nclear         : active-low clear to the digit chain
//   count_en           : clock enable to the least-significant digit
//   latch              : one-cycle capture strobe for the display register
//   overflow           : overflow flag of the last latched measurement
//   busy, state        : FSM status
interface freq_gate_ctrl_if;
  logic       run;
  logic       single;
  logic       abort;
  logic       chain_carry;
  logic       ctr_nclear;
  logic       count_en;
  logic       latch;
  logic       overflow;
  logic       busy;
  logic [1:0] state;

  modport master (
    output run, single, abort, chain_carry,
    input  ctr_nclear, count_en, latch, overflow, busy, state
  );

  modport slave (
    input  run, single, abort, chain_carry,
    output ctr_nclear, count_en, latch, overflow, busy, state
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Gate-timing controller for a BCD frequency counter.
// Each measurement clears the digit chain, opens the count gate for a fixed
// number of cycles, latches the result with its overflow flag, then holds.
// After the hold it repeats while run is high or a single request is
// pending; otherwise it returns to idle.
// Ports:
//   clk_in : single clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : freq_gate_ctrl_if.slave (requests in, chain controls and status out)
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES  = 1000000,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 500000,
  parameter int unsigned TMR_W        = 24
) (
  input logic             clk_in,
  input logic             reset,
  freq_gate_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StClear = 2'b01,
    StGate  = 2'b10,
    StHold  = 2'b11
  } state_e;

  // The timer is loaded with N-1 on entry, so a phase lasts N cycles.
  localparam logic [TMR_W-1:0] ClearLd = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] GateLd  = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HoldLd  = TMR_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pend_q, pend_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             overflow_q, overflow_d;
  logic             latch_q, latch_d;

  logic             go;
  logic             expired;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      pend_q     <= 1'b0;
      ovf_acc_q  <= 1'b0;
      overflow_q <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      ovf_acc_q  <= ovf_acc_d;
      overflow_q <= overflow_d;
      latch_q    <= latch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q - TMR_W'(1);
    pend_d     = pend_q | bus.single;
    ovf_acc_d  = ovf_acc_q;
    overflow_d = overflow_q;
    latch_d    = 1'b0;
    // A single arriving on the same edge counts as pending.
    go         = bus.run | pend_q | bus.single;
    expired    = (timer_q == '0);

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (go) begin
          state_d = StClear;
          timer_d = ClearLd;
          pend_d  = 1'b0;
        end
      end
      StClear: begin
        if (expired) begin
          state_d   = StGate;
          timer_d   = GateLd;
          ovf_acc_d = 1'b0;
        end
      end
      StGate: begin
        if (bus.chain_carry) ovf_acc_d = 1'b1;
        if (expired) begin
          state_d    = StHold;
          timer_d    = HoldLd;
          latch_d    = 1'b1;
          // Include a carry seen on the final gate cycle.
          overflow_d = ovf_acc_q | bus.chain_carry;
        end
      end
      StHold: begin
        if (expired) begin
          if (go) begin
            state_d = StClear;
            timer_d = ClearLd;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
            timer_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    // Abort outranks phase expiry; the previous overflow result is kept.
    if (bus.abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      timer_d    = '0;
      pend_d     = 1'b0;
      ovf_acc_d  = ovf_acc_q;
      overflow_d = overflow_q;
      latch_d    = 1'b0;
    end
  end

  always_comb begin
    bus.ctr_nclear = (state_q != StClear);
    bus.count_en   = (state_q == StGate);
    bus.latch      = latch_q;
    bus.overflow   = overflow_q;
    bus.busy       = (state_q != StIdle);
    bus.state      = state_q;
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl with GATE=10, CLEAR=2, HOLD=4.
// Each vector holds the inputs present at a rising edge and the outputs
// expected just after that edge.
module tb_freq_gate_ctrl;

  localparam int unsigned GateN  = 10;
  localparam int unsigned ClearN = 2;
  localparam int unsigned HoldN  = 4;

  typedef struct {
    bit         rst, run, sgl, abt, cry;
    bit         nclr, en, lat, ov, bsy;
    logic [1:0] st;
  } vec_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  freq_gate_ctrl_if bus ();

  freq_gate_ctrl #(
    .GATE_CYCLES  (GateN),
    .CLEAR_CYCLES (ClearN),
    .HOLD_CYCLES  (HoldN),
    .TMR_W        (8)
  ) u_dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(bit rst, bit run, bit sgl, bit abt, bit cry,
                              logic [1:0] st, bit lat, bit ov);
    vec_t v;
    v.rst = rst; v.run = run; v.sgl = sgl; v.abt = abt; v.cry = cry;
    v.st   = st;
    v.nclr = (st != 2'b01);
    v.en   = (st == 2'b10);
    v.bsy  = (st != 2'b00);
    v.lat  = lat;
    v.ov   = ov;
    return v;
  endfunction

  function automatic void rst_v(int n);
    for (int i = 0; i < n; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
  endfunction

  function automatic void idle(int n, bit cry, bit ov);
    for (int i = 0; i < n; i++) vecs.push_back(mk(0, 0, 0, 0, cry, 2'b00, 0, ov));
  endfunction

  // One measurement, vector k = edge k after the starting edge. ck: carry
  // edge, sgl_k: extra single, abort_k / rst_k: early termination (-1 = none).
  function automatic bit meas(bit run0, bit sgl0, bit runr, int ck, int sgl_k,
                              int abort_k, int rst_k, bit ov_old);
    bit         ov_new;
    bit         ov;
    bit         rst, run, sgl, abt, cry;
    logic [1:0] st;
    // Carry sampled at edges 3..12 falls in one of the 10 gate cycles.
    ov_new = (ck >= 3) && (ck <= 12);
    for (int k = 0; k < 16; k++) begin
      rst = (k == rst_k);
      run = (k == 0) ? run0 : runr;
      sgl = (k == 0) ? sgl0 : (k == sgl_k);
      abt = (k == abort_k);
      cry = (k == ck);
      ov  = (k >= 12) ? ov_new : ov_old;
      if (rst) begin
        vecs.push_back(mk(1, run, sgl, abt, cry, 2'b00, 0, 0));
        return 1'b0;
      end
      if (abt) begin
        vecs.push_back(mk(0, run, sgl, abt, cry, 2'b00, 0, ov));
        return ov;
      end
      st = (k < 2) ? 2'b01 : (k < 12) ? 2'b10 : 2'b11;
      vecs.push_back(mk(0, run, sgl, abt, cry, st, (k == 12), ov));
    end
    return ov_new;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    vec_t       e;
    logic [6:0] act, req;
    reset           = v.rst;
    bus.run         = v.run;
    bus.single      = v.sgl;
    bus.abort       = v.abt;
    bus.chain_carry = v.cry;
    sb.push_back(v);
    @(posedge clk_in);
    #1;
    e   = sb.pop_front();
    act = {bus.ctr_nclear, bus.count_en, bus.latch, bus.overflow, bus.busy, bus.state};
    req = {e.nclr, e.en, e.lat, e.ov, e.bsy, e.st};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d {nclr,en,lat,ov,busy,state}: got %b required %b", idx, act, req);
    end
  endtask

  initial begin
    bit ov;
    bus.run = 0; bus.single = 0; bus.abort = 0; bus.chain_carry = 0;
    ov = 0;

    rst_v(2);
    idle(3, 0, ov);
    // Single pulse, run low: one measurement then idle.
    ov = meas(0, 1, 0, -1, -1, -1, -1, ov);
    idle(3, 1, ov);  // carry while idle is ignored
    // Run high for three measurements, dropped during the third.
    ov = meas(1, 0, 1, -1, -1, -1, -1, ov);
    ov = meas(1, 0, 1, -1, -1, -1, -1, ov);
    ov = meas(1, 0, 0, -1, -1, -1, -1, ov);
    idle(2, 0, ov);
    // Carry on the last gate cycle, then a clean measurement.
    ov = meas(0, 1, 0, 12, -1, -1, -1, ov);
    idle(1, 0, ov);
    ov = meas(0, 1, 0, -1, -1, -1, -1, ov);
    idle(1, 0, ov);
    // Carry in the last clear cycle is ignored.
    ov = meas(0, 1, 0, 2, -1, -1, -1, ov);
    idle(1, 0, ov);
    // Carry on the first gate cycle plus a single queued mid-gate.
    ov = meas(0, 1, 0, 3, 5, -1, -1, ov);
    ov = meas(0, 0, 0, 13, -1, -1, -1, ov);  // carry in first hold ignored
    ov = meas(0, 1, 0, 7, -1, -1, -1, ov);
    idle(1, 0, ov);
    // Abort on the 5th gate cycle keeps overflow.
    ov = meas(0, 1, 0, -1, -1, 7, -1, ov);
    idle(4, 0, ov);
    // Single together with abort during gate: nothing restarts.
    ov = meas(0, 1, 0, -1, 8, 8, -1, ov);
    idle(4, 0, ov);
    // Set overflow, then reset mid-gate.
    ov = meas(0, 1, 0, 12, -1, -1, -1, ov);
    ov = meas(0, 1, 0, -1, -1, -1, 6, ov);
    idle(2, 0, ov);
    // Reset on the 2nd hold cycle with run high; restart on run later.
    ov = meas(0, 1, 1, 12, -1, -1, 14, ov);
    idle(3, 0, ov);
    ov = meas(1, 0, 0, -1, -1, -1, -1, ov);
    idle(2, 0, ov);

    foreach (vecs[i]) apply(vecs[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
